// File: rtl/io_mmio_ctrl_pkg.sv
// Shared definitions for the memory-mapped I/O block: word addresses,
// STATUS bit positions and register reset constants.
package io_mmio_ctrl_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] IO_ADDR_DISPLAY    = 10'h000;
    localparam logic [ADDR_W-1:0] IO_ADDR_LED        = 10'h001;
    localparam logic [ADDR_W-1:0] IO_ADDR_SWITCH     = 10'h002;
    localparam logic [ADDR_W-1:0] IO_ADDR_BUTTON     = 10'h003;
    localparam logic [ADDR_W-1:0] IO_ADDR_BTN_EVENT  = 10'h004;
    localparam logic [ADDR_W-1:0] IO_ADDR_BTN_IRQ_EN = 10'h005;
    localparam logic [ADDR_W-1:0] IO_ADDR_TIMER      = 10'h006;
    localparam logic [ADDR_W-1:0] IO_ADDR_TIMER_CMP  = 10'h007;
    localparam logic [ADDR_W-1:0] IO_ADDR_STATUS     = 10'h008;
    localparam logic [ADDR_W-1:0] IO_ADDR_BUF_BASE   = 10'h010;

    localparam int STATUS_TIMER_FLAG_BIT   = 0;
    localparam int STATUS_TIMER_IRQ_EN_BIT = 1;

    localparam logic [DATA_W-1:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

    // True when the word address lands inside a scratch buffer of the given depth.
    function automatic logic in_buf_range(input logic [ADDR_W-1:0] addr, input int depth);
        return (addr >= IO_ADDR_BUF_BASE) &&
               ((int'(addr) - int'(IO_ADDR_BUF_BASE)) < depth);
    endfunction

endpackage

// File: rtl/io_sync_edge.sv
// Multi-stage input synchroniser with a delayed copy of the synchronised
// level, giving a per-bit rising-edge pulse.
module io_sync_edge #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync_r [STAGES];
    logic [WIDTH-1:0] prev_r;

    // Synchroniser chain plus one extra flop holding the previous synchronised level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_r[i] <= '0;
            end
            prev_r <= '0;
        end else begin
            sync_r[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign level = sync_r[STAGES-1];
    assign rise  = sync_r[STAGES-1] & ~prev_r;

endmodule

// File: rtl/io_mmio_ctrl.sv
// Memory-mapped I/O block: display/LED outputs, synchronised switches and
// buttons with sticky edge events, compare timer, scratch buffer and irq.
module io_mmio_ctrl
    import io_mmio_ctrl_pkg::*;
#(
    parameter int          BUF_DEPTH    = 16,
    parameter int          SYNC_STAGES  = 2,
    parameter logic [31:0] DISPLAY_INIT = 32'h0000_0000,
    parameter logic [31:0] LED_INIT     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] switch_in,
    input  logic [31:0] button_in,
    input  logic        mem_write,
    input  logic [9:0]  mem_addr,
    input  logic [31:0] write_mem_data,
    output logic [31:0] read_mem_data,
    output logic [31:0] display_C,
    output logic [31:0] led_C,
    output logic        irq
);

    localparam int BUF_AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [31:0] switch_sync_s, button_sync_s, button_rise_s, switch_rise_unused_s;

    logic [31:0] display_r, led_r, btn_event_r, btn_irq_en_r;
    logic [31:0] timer_r, timer_cmp_r;
    logic        timer_flag_r, timer_irq_en_r, irq_r;
    logic [31:0] buf_mem_r [BUF_DEPTH];

    logic              wr_display_s, wr_led_s, wr_btn_event_s, wr_btn_irq_en_s;
    logic              wr_timer_s, wr_timer_cmp_s, wr_status_s, wr_buf_s, buf_hit_s;
    logic [BUF_AW-1:0] buf_idx_s;
    logic [31:0]       timer_nxt_s, btn_event_nxt_s, evt_clr_s, rdata_s;
    logic              timer_set_s, timer_flag_nxt_s, irq_nxt_s;

    io_sync_edge #(.WIDTH(32), .STAGES(SYNC_STAGES)) u_sync_switch (
        .clk   (clk),
        .rst   (rst),
        .din   (switch_in),
        .level (switch_sync_s),
        .rise  (switch_rise_unused_s)
    );

    io_sync_edge #(.WIDTH(32), .STAGES(SYNC_STAGES)) u_sync_button (
        .clk   (clk),
        .rst   (rst),
        .din   (button_in),
        .level (button_sync_s),
        .rise  (button_rise_s)
    );

    // Write decode; SWITCH, BUTTON and unmapped words fall through with no strobe
    always_comb begin
        wr_display_s    = 1'b0;
        wr_led_s        = 1'b0;
        wr_btn_event_s  = 1'b0;
        wr_btn_irq_en_s = 1'b0;
        wr_timer_s      = 1'b0;
        wr_timer_cmp_s  = 1'b0;
        wr_status_s     = 1'b0;
        wr_buf_s        = 1'b0;
        buf_hit_s       = in_buf_range(mem_addr, BUF_DEPTH);
        buf_idx_s       = BUF_AW'(mem_addr - IO_ADDR_BUF_BASE);
        if (mem_write) begin
            case (mem_addr)
                IO_ADDR_DISPLAY:    wr_display_s    = 1'b1;
                IO_ADDR_LED:        wr_led_s        = 1'b1;
                IO_ADDR_BTN_EVENT:  wr_btn_event_s  = 1'b1;
                IO_ADDR_BTN_IRQ_EN: wr_btn_irq_en_s = 1'b1;
                IO_ADDR_TIMER:      wr_timer_s      = 1'b1;
                IO_ADDR_TIMER_CMP:  wr_timer_cmp_s  = 1'b1;
                IO_ADDR_STATUS:     wr_status_s     = 1'b1;
                default:            wr_buf_s        = buf_hit_s;
            endcase
        end else begin
            wr_buf_s = 1'b0;
        end
    end

    // Next-state for timer, sticky flags and irq; a new set always beats a W1C clear
    always_comb begin
        timer_nxt_s = timer_r + 32'd1;
        timer_set_s = 1'b0;
        if (wr_timer_s) begin
            timer_nxt_s = write_mem_data;
            timer_set_s = 1'b0;
        end else if (timer_r == timer_cmp_r) begin
            timer_nxt_s = 32'd0;
            timer_set_s = 1'b1;
        end else begin
            timer_nxt_s = timer_r + 32'd1;
            timer_set_s = 1'b0;
        end
        timer_flag_nxt_s = timer_set_s |
            (timer_flag_r & ~(wr_status_s & write_mem_data[STATUS_TIMER_FLAG_BIT]));
        evt_clr_s        = wr_btn_event_s ? write_mem_data : 32'd0;
        btn_event_nxt_s  = button_rise_s | (btn_event_r & ~evt_clr_s);
        irq_nxt_s        = (|(btn_event_r & btn_irq_en_r)) | (timer_flag_r & timer_irq_en_r);
    end

    // Control/status register file, timer and irq
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            display_r      <= DISPLAY_INIT;
            led_r          <= LED_INIT;
            btn_event_r    <= 32'd0;
            btn_irq_en_r   <= 32'd0;
            timer_r        <= 32'd0;
            timer_cmp_r    <= TIMER_CMP_RST;
            timer_flag_r   <= 1'b0;
            timer_irq_en_r <= 1'b0;
            irq_r          <= 1'b0;
        end else begin
            if (wr_display_s)    display_r    <= write_mem_data;
            if (wr_led_s)        led_r        <= write_mem_data;
            if (wr_btn_irq_en_s) btn_irq_en_r <= write_mem_data;
            if (wr_timer_cmp_s)  timer_cmp_r  <= write_mem_data;
            if (wr_status_s)     timer_irq_en_r <= write_mem_data[STATUS_TIMER_IRQ_EN_BIT];
            btn_event_r  <= btn_event_nxt_s;
            timer_r      <= timer_nxt_s;
            timer_flag_r <= timer_flag_nxt_s;
            irq_r        <= irq_nxt_s;
        end
    end

    // Scratch buffer storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem_r[i] <= 32'd0;
            end
        end else if (wr_buf_s) begin
            buf_mem_r[buf_idx_s] <= write_mem_data;
        end
    end

    // Zero-latency read mux
    always_comb begin
        rdata_s = 32'd0;
        case (mem_addr)
            IO_ADDR_DISPLAY:    rdata_s = display_r;
            IO_ADDR_LED:        rdata_s = led_r;
            IO_ADDR_SWITCH:     rdata_s = switch_sync_s;
            IO_ADDR_BUTTON:     rdata_s = button_sync_s;
            IO_ADDR_BTN_EVENT:  rdata_s = btn_event_r;
            IO_ADDR_BTN_IRQ_EN: rdata_s = btn_irq_en_r;
            IO_ADDR_TIMER:      rdata_s = timer_r;
            IO_ADDR_TIMER_CMP:  rdata_s = timer_cmp_r;
            IO_ADDR_STATUS: begin
                rdata_s[STATUS_TIMER_FLAG_BIT]   = timer_flag_r;
                rdata_s[STATUS_TIMER_IRQ_EN_BIT] = timer_irq_en_r;
            end
            default: begin
                if (buf_hit_s) begin
                    rdata_s = buf_mem_r[buf_idx_s];
                end else begin
                    rdata_s = 32'd0;
                end
            end
        endcase
    end

    assign read_mem_data = rdata_s;
    assign display_C     = display_r;
    assign led_C         = led_r;
    assign irq           = irq_r;

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Self-checking bench for io_mmio_ctrl: a register-level reference model
// compared every cycle, plus directed checks with hand-computed values.
module tb_io_mmio_ctrl;

    localparam int          BUF_DEPTH    = 16;
    localparam int          S            = 2;
    localparam logic [31:0] DISPLAY_INIT = 32'h1234_5678;
    localparam logic [31:0] LED_INIT     = 32'h0000_00F0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] switch_in = 32'd0;
    logic [31:0] button_in = 32'd0;
    logic        mem_write = 1'b0;
    logic [9:0]  mem_addr = 10'd0;
    logic [31:0] write_mem_data = 32'd0;
    logic [31:0] read_mem_data, display_C, led_C;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    io_mmio_ctrl #(
        .BUF_DEPTH(BUF_DEPTH), .SYNC_STAGES(S),
        .DISPLAY_INIT(DISPLAY_INIT), .LED_INIT(LED_INIT)
    ) dut (
        .clk(clk), .rst(rst), .switch_in(switch_in), .button_in(button_in),
        .mem_write(mem_write), .mem_addr(mem_addr), .write_mem_data(write_mem_data),
        .read_mem_data(read_mem_data), .display_C(display_C), .led_C(led_C), .irq(irq)
    );

    // Reference state: architectural registers plus pin sample history
    logic [31:0] m_disp, m_led, m_evt, m_en, m_tmr, m_cmp;
    logic        m_flag, m_tien, m_irq;
    logic [31:0] m_buf [BUF_DEPTH];
    logic [31:0] sw_hist [S];
    logic [31:0] bt_hist [S];
    logic [31:0] bt_seen;

    function automatic logic [31:0] model_read(input logic [9:0] a);
        int off;
        off = int'(a) - 16;
        case (a)
            10'h000: return m_disp;
            10'h001: return m_led;
            10'h002: return sw_hist[S-1];
            10'h003: return bt_hist[S-1];
            10'h004: return m_evt;
            10'h005: return m_en;
            10'h006: return m_tmr;
            10'h007: return m_cmp;
            10'h008: return {30'd0, m_tien, m_flag};
            default: begin
                if (off >= 0 && off < BUF_DEPTH) return m_buf[off];
                return 32'd0;
            end
        endcase
    endfunction

    // Reference model update: pins seen S edges ago are the visible level
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_disp <= DISPLAY_INIT; m_led <= LED_INIT; m_evt <= 32'd0; m_en <= 32'd0;
            m_tmr <= 32'd0; m_cmp <= 32'hFFFF_FFFF; m_flag <= 1'b0; m_tien <= 1'b0;
            m_irq <= 1'b0; bt_seen <= 32'd0;
            for (int i = 0; i < BUF_DEPTH; i++) m_buf[i] <= 32'd0;
            for (int i = 0; i < S; i++) begin sw_hist[i] <= 32'd0; bt_hist[i] <= 32'd0; end
        end else begin
            sw_hist[0] <= switch_in;
            bt_hist[0] <= button_in;
            for (int i = 1; i < S; i++) begin sw_hist[i] <= sw_hist[i-1]; bt_hist[i] <= bt_hist[i-1]; end
            bt_seen <= bt_hist[S-1];
            m_evt <= (bt_hist[S-1] & ~bt_seen) |
                     (m_evt & ~((mem_write && mem_addr == 10'h004) ? write_mem_data : 32'd0));
            m_irq <= ((m_evt & m_en) != 32'd0) || (m_flag && m_tien);
            if (mem_write && mem_addr == 10'h006) m_tmr <= write_mem_data;
            else if (m_tmr == m_cmp)               m_tmr <= 32'd0;
            else                                   m_tmr <= m_tmr + 32'd1;
            m_flag <= (!(mem_write && mem_addr == 10'h006) && m_tmr == m_cmp) ||
                      (m_flag && !(mem_write && mem_addr == 10'h008 && write_mem_data[0]));
            if (mem_write) begin
                case (mem_addr)
                    10'h000: m_disp <= write_mem_data;
                    10'h001: m_led  <= write_mem_data;
                    10'h005: m_en   <= write_mem_data;
                    10'h007: m_cmp  <= write_mem_data;
                    10'h008: m_tien <= write_mem_data[1];
                    default: begin
                        if (int'(mem_addr) >= 16 && int'(mem_addr) < 16 + BUF_DEPTH)
                            m_buf[int'(mem_addr) - 16] <= write_mem_data;
                    end
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the reference model
    always @(negedge clk) begin
        if (rst) begin
            check("model_rdata", read_mem_data, model_read(mem_addr));
            check("model_display", display_C, m_disp);
            check("model_led", led_C, m_led);
            check("model_irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        mem_write = 1'b1; mem_addr = a; write_mem_data = d;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic rd(input string name, input logic [9:0] a, input logic [31:0] exp);
        mem_addr = a;
        #1;
        check(name, read_mem_data, exp);
        tick();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        // Reset defaults
        rd("rst_display", 10'h000, DISPLAY_INIT);
        rd("rst_cmp", 10'h007, 32'hFFFF_FFFF);
        rd("rst_buf3", 10'h013, 32'd0);
        check("rst_led", led_C, LED_INIT);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // Output registers and read-only words
        wr(10'h000, 32'hDEAD_BEEF);
        check("display_wr", display_C, 32'hDEAD_BEEF);
        wr(10'h001, 32'h0000_0005);
        check("led_wr", led_C, 32'h0000_0005);
        rd("display_rd", 10'h000, 32'hDEAD_BEEF);

        // Switch synchroniser latency
        switch_in = 32'h0000_00A5;
        mem_addr = 10'h002;
        for (int k = 1; k <= S; k++) begin
            tick();
            check("switch_sync", read_mem_data, (k == S) ? 32'h0000_00A5 : 32'd0);
        end
        wr(10'h002, 32'h0000_1234);
        rd("switch_ro", 10'h002, 32'h0000_00A5);
        wr(10'h003, 32'h0000_FFFF);
        rd("button_ro", 10'h003, 32'd0);

        // Button event and irq
        wr(10'h005, 32'h0000_0004);
        button_in = 32'h0000_0004;
        repeat (S) tick();
        mem_addr = 10'h004; #1;
        check("evt_before", read_mem_data, 32'd0);
        tick();
        check("evt_set", read_mem_data, 32'h0000_0004);
        check("irq_lag", {31'd0, irq}, 32'd0);
        tick();
        check("irq_rise", {31'd0, irq}, 32'd1);
        repeat (8) tick();
        check("evt_held", read_mem_data, 32'h0000_0004);
        wr(10'h004, 32'd0);
        rd("evt_w0", 10'h004, 32'h0000_0004);
        wr(10'h004, 32'h0000_0004);
        mem_addr = 10'h004; #1;
        check("evt_clr", read_mem_data, 32'd0);
        check("irq_hold", {31'd0, irq}, 32'd1);
        tick();
        check("irq_fall", {31'd0, irq}, 32'd0);
        button_in = 32'd0;
        repeat (4) tick();
        check("evt_fall", read_mem_data, 32'd0);
        button_in = 32'h0000_0004;
        repeat (S) tick();
        wr(10'h004, 32'h0000_0004);
        mem_addr = 10'h004; #1;
        check("evt_rise_wins", read_mem_data, 32'h0000_0004);
        tick();
        wr(10'h004, 32'h0000_0004);
        wr(10'h005, 32'd0);

        // Compare timer
        wr(10'h007, 32'd9);
        wr(10'h006, 32'd0);
        wr(10'h008, 32'h0000_0002);
        for (int k = 1; k <= 11; k++) begin
            mem_addr = 10'h006; #1;
            check("timer_seq", read_mem_data, 32'(k % 10));
            if (k == 10) begin
                mem_addr = 10'h008; #1;
                check("timer_flag", read_mem_data, 32'h0000_0003);
                check("timer_irq_lag", {31'd0, irq}, 32'd0);
            end
            if (k == 11) check("timer_irq", {31'd0, irq}, 32'd1);
            tick();
        end
        wr(10'h008, 32'h0000_0003);
        mem_addr = 10'h008; #1;
        check("flag_clr", read_mem_data, 32'h0000_0002);
        check("irq_after_clr", {31'd0, irq}, 32'd1);
        tick();
        check("irq_drop", {31'd0, irq}, 32'd0);
        repeat (5) tick();
        wr(10'h008, 32'h0000_0003);
        mem_addr = 10'h008; #1;
        check("flag_set_wins", read_mem_data, 32'h0000_0003);
        mem_addr = 10'h006; #1;
        check("timer_wrap", read_mem_data, 32'd0);
        tick();
        wr(10'h007, 32'hFFFF_FFFF);
        wr(10'h008, 32'h0000_0001);

        // Scratch buffer bounds
        wr(10'h010, 32'h0000_0011);
        wr(10'h01F, 32'h0000_0077);
        rd("buf_last", 10'h01F, 32'h0000_0077);
        wr(10'h020, 32'h0000_0099);
        rd("buf_past", 10'h020, 32'd0);
        rd("buf_first", 10'h010, 32'h0000_0011);
        wr(10'h009, 32'h0000_0055);
        rd("unmapped", 10'h009, 32'd0);
        rd("unmapped_top", 10'h3FF, 32'd0);

        // Asynchronous reset mid-operation with a write in flight
        repeat (3) tick();
        mem_write = 1'b1; mem_addr = 10'h000; write_mem_data = 32'hCAFE_F00D;
        rst = 1'b0;
        #1;
        check("rst_async_display", display_C, DISPLAY_INIT);
        mem_addr = 10'h006; #1;
        check("rst_async_timer", read_mem_data, 32'd0);
        check("rst_async_irq", {31'd0, irq}, 32'd0);
        mem_addr = 10'h000;
        tick();
        tick();
        mem_write = 1'b0;
        rst = 1'b1;
        check("rst_write_dropped", display_C, DISPLAY_INIT);
        rd("rst_buf_clr", 10'h01F, 32'd0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
